// File: rtl/stage4_mem_access_if.sv
// rtl/stage4_mem_access_if.sv - data-memory req/ack bus between the mem-access stage and dmem
//
// Purpose : bundles the data-memory handshake so the stage and the memory model
//           share one typed connection.
// Signals : dmem_req   stage->mem  access request, held until ack
//           dmem_we    stage->mem  1=store, 0=load
//           dmem_addr  stage->mem  word-aligned address
//           dmem_wstrb stage->mem  byte-lane write strobes
//           dmem_wdata stage->mem  lane-replicated store data
//           dmem_ack   mem->stage  access completes on the cycle it is high
//           dmem_rdata mem->stage  read word, valid with dmem_ack
// Also supplies the instruction-type encoding used on instr_type when the
// surrounding decode package has not already defined it.

`ifndef RANGE_INSTRS
`define RANGE_INSTRS 3:0
`endif
`ifndef DO_LOAD
`define DO_LOAD 4'd2
`endif
`ifndef DO_STORE
`define DO_STORE 4'd3
`endif

interface stage4_mem_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/stage4_mem_access.sv
// rtl/stage4_mem_access.sv - memory-access pipeline stage with req/ack data-memory handshake
//
// Purpose : takes the execute result (eval) as effective address and rs2_val as
//           store data, runs a variable-latency req/ack access to data memory and
//           returns an extended load value (or eval for non-memory ops) to writeback.
// Build option: MISALIGN_TRAP_EN - when defined, misaligned half/word accesses are
//           trapped (no request, misaligned=1); otherwise low offending address bits
//           are ignored and misaligned stays 0.
// Ports   : clock, reset        rising-edge clock, synchronous active-high reset
//           is_mem_stage        start strobe, sampled only in IDLE
//           instr_type, funct3  decoded op type and access size/sign
//           eval, rs2_val       effective address / ALU result, store data
//           dmem                data-memory bus (master side)
//           mem_busy, mem_done  stall indication, one-cycle completion pulse
//           load_val            result toward writeback, held until next mem_done
//           fault, misaligned   sticky status, cleared by the next accepted start

module stage4_mem_access #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 is_mem_stage,
  input  logic [`RANGE_INSTRS] instr_type,
  input  logic [2:0]           funct3,
  input  logic [31:0]          eval,
  input  logic [31:0]          rs2_val,
  stage4_mem_access_if.master  dmem,
  output logic                 mem_busy,
  output logic                 mem_done,
  output logic [31:0]          load_val,
  output logic                 fault,
  output logic                 misaligned
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t state, state_nxt;

  logic             is_load, is_store, is_mem, f3_legal, mis_trap, timeout_hit;
  logic [3:0]       wstrb_nxt;
  logic [31:0]      wdata_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      addr_q, wdata_q;
  logic [3:0]       wstrb_q;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [1:0]       lane_q;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      load_ext;

  // ---------------- start decode ----------------
  always_comb begin
    is_load  = (instr_type == `DO_LOAD);
    is_store = (instr_type == `DO_STORE);
    is_mem   = is_load | is_store;

    // Stores only have the three unsigned-less sizes; 1xx is never a store.
    case (funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = is_load;
      default:                f3_legal = 1'b0;
    endcase

`ifdef MISALIGN_TRAP_EN
    // funct3[1:0]: 01 = half (LH/LHU/SH), 10 = word (LW/SW).
    mis_trap = ((funct3[1:0] == 2'b01) && eval[0]) ||
               ((funct3[1:0] == 2'b10) && (eval[1:0] != 2'b00));
`else
    mis_trap = 1'b0;
`endif

    wstrb_nxt = 4'b0000;
    wdata_nxt = rs2_val;
    case (funct3[1:0])
      2'b00: begin
        wstrb_nxt = 4'b0001 << eval[1:0];
        wdata_nxt = {4{rs2_val[7:0]}};
      end
      2'b01: begin
        wstrb_nxt = 4'b0011 << {eval[1], 1'b0};
        wdata_nxt = {2{rs2_val[15:0]}};
      end
      default: begin
        wstrb_nxt = 4'b1111;
        wdata_nxt = rs2_val;
      end
    endcase
    if (!is_store) wstrb_nxt = 4'b0000;
  end

  // Counter holds the number of REQ cycles already spent without ack, so the
  // last permitted cycle is when it equals TIMEOUT_CYCLES-1.
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // ---------------- load extraction ----------------
  always_comb begin
    case (lane_q)
      2'd0:    byte_sel = dmem.dmem_rdata[7:0];
      2'd1:    byte_sel = dmem.dmem_rdata[15:8];
      2'd2:    byte_sel = dmem.dmem_rdata[23:16];
      default: byte_sel = dmem.dmem_rdata[31:24];
    endcase
    half_sel = lane_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];

    case (f3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = dmem.dmem_rdata;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (is_mem_stage) begin
          if (is_mem && f3_legal && !mis_trap) state_nxt = S_REQ;
          else                                 state_nxt = S_DONE;
        end
      end
      S_REQ: begin
        // Ack is checked first so an ack on the timeout edge still completes cleanly.
        if (dmem.dmem_ack || timeout_hit) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign mem_busy        = (state == S_REQ);
  assign mem_done        = (state == S_DONE);
  assign dmem.dmem_req   = (state == S_REQ);
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wstrb = wstrb_q;
  assign dmem.dmem_wdata = wdata_q;

  // ---------------- datapath ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      we_q     <= 1'b0;
      f3_q     <= '0;
      lane_q   <= '0;
      load_val <= '0;
      fault    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misaligned <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (is_mem_stage) begin
            fault <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misaligned <= 1'b0;
`endif
            if (!is_mem) begin
              load_val <= eval;
            end else if (!f3_legal) begin
              fault    <= 1'b1;
              load_val <= '0;
            end else if (mis_trap) begin
`ifdef MISALIGN_TRAP_EN
              misaligned <= 1'b1;
`endif
              load_val <= '0;
            end else begin
              cnt     <= '0;
              addr_q  <= {eval[31:2], 2'b00};
              wdata_q <= wdata_nxt;
              wstrb_q <= wstrb_nxt;
              we_q    <= is_store;
              f3_q    <= funct3;
              lane_q  <= eval[1:0];
            end
          end
        end
        S_REQ: begin
          if (dmem.dmem_ack) begin
            if (!we_q) load_val <= load_ext;
          end else if (timeout_hit) begin
            fault    <= 1'b1;
            load_val <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifndef MISALIGN_TRAP_EN
  assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_stage4_mem_access.sv
// tb/tb_stage4_mem_access.sv - directed scoreboard bench for stage4_mem_access

`ifndef RANGE_INSTRS
`define RANGE_INSTRS 3:0
`endif
`ifndef DO_LOAD
`define DO_LOAD 4'd2
`endif
`ifndef DO_STORE
`define DO_STORE 4'd3
`endif

`timescale 1ns/1ps

module tb_stage4_mem_access;

  localparam logic [3:0] OP_ALU   = 4'd0;
  localparam logic [3:0] OP_LOAD  = `DO_LOAD;
  localparam logic [3:0] OP_STORE = `DO_STORE;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 is_mem_stage = 1'b0;
  logic [`RANGE_INSTRS] instr_type = '0;
  logic [2:0]           funct3 = '0;
  logic [31:0]          eval = '0;
  logic [31:0]          rs2_val = '0;
  logic                 mem_busy, mem_done, fault, misaligned;
  logic [31:0]          load_val;

  stage4_mem_access_if dmem_bus ();

  stage4_mem_access #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .is_mem_stage (is_mem_stage),
    .instr_type   (instr_type),
    .funct3       (funct3),
    .eval         (eval),
    .rs2_val      (rs2_val),
    .dmem         (dmem_bus),
    .mem_busy     (mem_busy),
    .mem_done     (mem_done),
    .load_val     (load_val),
    .fault        (fault),
    .misaligned   (misaligned)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          chk_val;
    logic [31:0] val;
    logic        flt;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_res(input bit cv, input logic [31:0] v, input logic f, input logic m);
    exp_t e;
    e.chk_val = cv;
    e.val     = v;
    e.flt     = f;
    e.mis     = m;
    sb.push_back(e);
  endtask

  // Drives one start strobe in the current cycle; returns in the following cycle.
  task automatic start(input logic [3:0] it, input logic [2:0] f3,
                       input logic [31:0] ev, input logic [31:0] rs2);
    instr_type   = it;
    funct3       = f3;
    eval         = ev;
    rs2_val      = rs2;
    is_mem_stage = 1'b1;
    step();
    is_mem_stage = 1'b0;
  endtask

  // Scoreboard: every completion pulse consumes one expected result.
  always @(negedge clock) begin
    if (!reset && mem_done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", {31'd0, mem_done}, 32'd0);
      end else begin
        e_mon = sb.pop_front();
        if (e_mon.chk_val) chk("sb_load_val", load_val, e_mon.val);
        chk("sb_fault", {31'd0, fault}, {31'd0, e_mon.flt});
        chk("sb_misaligned", {31'd0, misaligned}, {31'd0, e_mon.mis});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int busy_cnt;
  int req_cnt;

  initial begin
    dmem_bus.dmem_ack   = 1'b0;
    dmem_bus.dmem_rdata = '0;

    // ---- reset state ----
    step();
    step();
    chk("rst_req", {31'd0, dmem_bus.dmem_req}, 32'd0);
    chk("rst_busy", {31'd0, mem_busy}, 32'd0);
    chk("rst_done", {31'd0, mem_done}, 32'd0);
    chk("rst_load_val", load_val, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_mis", {31'd0, misaligned}, 32'd0);
    chk("rst_addr", dmem_bus.dmem_addr, 32'd0);
    reset = 1'b0;

    // ---- LB at 0x103, ack on 4th REQ cycle (also the timeout edge), start during REQ ignored ----
    expect_res(1, 32'hFFFF_FF80, 0, 0);
    start(OP_LOAD, 3'b000, 32'h103, 32'h0);
    busy_cnt = 0;
    if (mem_busy) busy_cnt++;
    chk("lb_req", {31'd0, dmem_bus.dmem_req}, 32'd1);
    chk("lb_we", {31'd0, dmem_bus.dmem_we}, 32'd0);
    chk("lb_addr", dmem_bus.dmem_addr, 32'h100);
    chk("lb_wstrb", {28'd0, dmem_bus.dmem_wstrb}, 32'd0);
    step();
    if (mem_busy) busy_cnt++;
    is_mem_stage = 1'b1;
    instr_type   = OP_ALU;
    eval         = 32'h999;
    step();
    is_mem_stage = 1'b0;
    if (mem_busy) busy_cnt++;
    chk("lb_addr_stable", dmem_bus.dmem_addr, 32'h100);
    step();
    if (mem_busy) busy_cnt++;
    dmem_bus.dmem_ack   = 1'b1;
    dmem_bus.dmem_rdata = 32'h80FF_1234;
    step();
    dmem_bus.dmem_ack = 1'b0;
    if (mem_busy) busy_cnt++;
    chk("lb_done", {31'd0, mem_done}, 32'd1);
    chk("lb_busy_cycles", busy_cnt, 32'd4);
    chk("lb_req_drop", {31'd0, dmem_bus.dmem_req}, 32'd0);
    step();
    chk("lb_done_one_cycle", {31'd0, mem_done}, 32'd0);

    // ---- SH at 0x202, ack same cycle as req ----
    expect_res(0, 32'h0, 0, 0);
    start(OP_STORE, 3'b001, 32'h202, 32'hDEAD_BEEF);
    chk("sh_req", {31'd0, dmem_bus.dmem_req}, 32'd1);
    chk("sh_we", {31'd0, dmem_bus.dmem_we}, 32'd1);
    chk("sh_addr", dmem_bus.dmem_addr, 32'h200);
    chk("sh_wstrb", {28'd0, dmem_bus.dmem_wstrb}, 32'hC);
    chk("sh_wdata", dmem_bus.dmem_wdata, 32'hBEEF_BEEF);
    dmem_bus.dmem_ack = 1'b1;
    step();
    dmem_bus.dmem_ack = 1'b0;
    chk("sh_done_cycle2", {31'd0, mem_done}, 32'd1);
    step();

    // ---- SB at 0x3 ----
    expect_res(0, 32'h0, 0, 0);
    start(OP_STORE, 3'b000, 32'h3, 32'h1234_56A5);
    chk("sb_wstrb", {28'd0, dmem_bus.dmem_wstrb}, 32'h8);
    chk("sb_wdata", dmem_bus.dmem_wdata, 32'hA5A5_A5A5);
    dmem_bus.dmem_ack = 1'b1;
    step();
    dmem_bus.dmem_ack = 1'b0;
    step();

    // ---- LHU at 0x10 ----
    expect_res(1, 32'h0000_8001, 0, 0);
    start(OP_LOAD, 3'b101, 32'h10, 32'h0);
    dmem_bus.dmem_ack   = 1'b1;
    dmem_bus.dmem_rdata = 32'h0000_8001;
    step();
    dmem_bus.dmem_ack = 1'b0;
    chk("lhu_val", load_val, 32'h0000_8001);
    step();

    // ---- LH at 0x12, upper half sign-extended ----
    expect_res(1, 32'hFFFF_8001, 0, 0);
    start(OP_LOAD, 3'b001, 32'h12, 32'h0);
    dmem_bus.dmem_ack   = 1'b1;
    dmem_bus.dmem_rdata = 32'h8001_7FFF;
    step();
    dmem_bus.dmem_ack = 1'b0;
    step();

    // ---- non-memory pass-through ----
    expect_res(1, 32'h55, 0, 0);
    start(OP_ALU, 3'b000, 32'h55, 32'h0);
    chk("alu_done_lat1", {31'd0, mem_done}, 32'd1);
    chk("alu_busy", {31'd0, mem_busy}, 32'd0);
    chk("alu_val", load_val, 32'h55);
    step();

    // ---- timeout: no ack for TIMEOUT_CYCLES=4 ----
    expect_res(1, 32'h0, 1, 0);
    start(OP_LOAD, 3'b010, 32'h40, 32'h0);
    req_cnt = 0;
    for (int i = 0; i < 20 && mem_done !== 1'b1; i++) begin
      if (dmem_bus.dmem_req === 1'b1) req_cnt++;
      step();
    end
    chk("to_done_seen", {31'd0, mem_done}, 32'd1);
    chk("to_req_cycles", req_cnt, 32'd4);
    chk("to_fault", {31'd0, fault}, 32'd1);
    chk("to_req_low", {31'd0, dmem_bus.dmem_req}, 32'd0);
    step();
    expect_res(1, 32'h7, 0, 0);
    start(OP_ALU, 3'b000, 32'h7, 32'h0);
    chk("to_fault_cleared", {31'd0, fault}, 32'd0);
    step();

    // ---- illegal funct3 on a load ----
    expect_res(1, 32'h0, 1, 0);
    start(OP_LOAD, 3'b011, 32'h20, 32'h0);
    chk("ill_no_req", {31'd0, dmem_bus.dmem_req}, 32'd0);
    chk("ill_done", {31'd0, mem_done}, 32'd1);
    step();

    // ---- LW at 0x6 ----
`ifdef MISALIGN_TRAP_EN
    expect_res(1, 32'h0, 0, 1);
    start(OP_LOAD, 3'b010, 32'h6, 32'h0);
    chk("lw6_no_req", {31'd0, dmem_bus.dmem_req}, 32'd0);
    chk("lw6_mis", {31'd0, misaligned}, 32'd1);
    step();
`else
    expect_res(1, 32'h1122_3344, 0, 0);
    start(OP_LOAD, 3'b010, 32'h6, 32'h0);
    chk("lw6_req", {31'd0, dmem_bus.dmem_req}, 32'd1);
    chk("lw6_addr", dmem_bus.dmem_addr, 32'h4);
    dmem_bus.dmem_ack   = 1'b1;
    dmem_bus.dmem_rdata = 32'h1122_3344;
    step();
    dmem_bus.dmem_ack = 1'b0;
    chk("lw6_mis", {31'd0, misaligned}, 32'd0);
    step();
`endif

    // ---- reset during REQ ----
    start(OP_LOAD, 3'b010, 32'h80, 32'h0);
    chk("rq_req", {31'd0, dmem_bus.dmem_req}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rq_req_low", {31'd0, dmem_bus.dmem_req}, 32'd0);
    chk("rq_no_done", {31'd0, mem_done}, 32'd0);
    step();
    chk("rq_no_done2", {31'd0, mem_done}, 32'd0);

    // ---- stray ack in IDLE ----
    dmem_bus.dmem_ack = 1'b1;
    step();
    step();
    dmem_bus.dmem_ack = 1'b0;
    chk("stray_no_done", {31'd0, mem_done}, 32'd0);
    chk("stray_no_busy", {31'd0, mem_busy}, 32'd0);
    step();

    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
